// File: rtl/barrel_shift_pipe_if.sv
// barrel_shift_pipe_if: request/result valid-ready bundle for barrel_shift_pipe.
interface barrel_shift_pipe_if #(parameter int WIDTH = 16, parameter int SHW = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  modport master (output in_valid, in_data, in_amt, in_op, out_ready,
                  input in_ready, out_valid, out_data, out_carry, out_zero);
  modport slave (input in_valid, in_data, in_amt, in_op, out_ready,
                 output in_ready, out_valid, out_data, out_carry, out_zero);
endinterface

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: 2-stage valid/ready pipe around a SLL/SRL/SRA/ROR barrel shifter with carry/zero flags.
module barrel_shift_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input logic              clk,
  input logic              rst_n,
  barrel_shift_pipe_if.slave bus
);
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [SHW-1:0]   s1_amt_q;
  logic [1:0]       s1_op_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_carry_q;
  logic             out_zero_q;
  logic             adv;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] ct;
  logic             carry_d;
  // WIDTH:1 mux with reversed select: s=0 picks a[WIDTH-1], so index is ~s.
  function automatic logic pick(input logic [WIDTH-1:0] a, input logic [SHW-1:0] s);
    logic [SHW-1:0] r;
    r = ~s;
    return a[r];
  endfunction
  assign adv = ~out_valid_q | bus.out_ready;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [WIDTH-1:0] t;
    for (genvar k = 0; k < WIDTH; k++) begin : g_tap
      localparam int L = (i >= k) ? i - k : 0;
      localparam int R = (i + k < WIDTH) ? i + k : WIDTH - 1;
      assign t[WIDTH-1-k] = s1_op_q == 2'b00 ? ((i >= k) ? s1_data_q[L] : 1'b0)
                          : s1_op_q == 2'b01 ? ((i + k < WIDTH) ? s1_data_q[R] : 1'b0)
                          : s1_op_q == 2'b10 ? s1_data_q[R]
                          : s1_data_q[(i + k) % WIDTH];
    end
    assign res_d[i] = pick(t, s1_amt_q);
  end
  for (genvar k = 0; k < WIDTH; k++) begin : g_ct
    localparam int CL = (k > 0) ? WIDTH - k : 0;
    localparam int CR = (k > 0) ? k - 1 : 0;
    assign ct[WIDTH-1-k] = (k > 0) && (s1_op_q == 2'b00 ? s1_data_q[CL] : s1_data_q[CR]);
  end
  assign carry_d = s1_op_q == 2'b11 ? (|s1_amt_q) & res_d[WIDTH-1] : pick(ct, s1_amt_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_amt_q    <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_q <= bus.in_data;
        s1_amt_q  <= bus.in_amt;
        s1_op_q   <= bus.in_op;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q  <= res_d;
        out_carry_q <= carry_d;
        out_zero_q  <= ~|res_d;
      end
    end
  end
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_zero  = out_zero_q;
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed vectors, backpressure/reset sequences and randomized stream vs a queue model.
module tb_barrel_shift_pipe;
  typedef struct {
    logic [1:0]  op;
    int          a;
    logic [15:0] d;
    logic [15:0] ed;
    logic        ec;
  } vec_t;
  typedef struct {
    logic [15:0] d;
    logic        c;
  } res_t;
  logic clk;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  int drained = 0;
  res_t q[$];
  logic stall_prev = 1'b0;
  logic [15:0] last_data;
  logic last_c;
  vec_t tv[14];
  logic pend, acc;
  logic [15:0] rd;
  logic [3:0] ra;
  logic [1:0] ro;
  int idx, d0;
  barrel_shift_pipe_if #(.WIDTH(16), .SHW(4)) bus ();
  barrel_shift_pipe #(.WIDTH(16), .SHW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic res_t model(input logic [15:0] d, input int a, input logic [1:0] op);
    logic [31:0] w;
    res_t r;
    case (op)
      2'b00: begin w = {16'b0, d} << a; r.d = w[15:0]; r.c = w[16]; end
      2'b01: begin w = {d, 16'b0} >> a; r.d = w[31:16]; r.c = w[15]; end
      2'b10: begin w = $unsigned($signed({d, 16'b0}) >>> a); r.d = w[31:16]; r.c = w[15]; end
      default: begin r.d = (d >> a) | (d << (16 - a)); r.c = (a != 0) & r.d[15]; end
    endcase
    return r;
  endfunction
  task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] a, input logic [1:0] op,
                       input logic ordy, output logic accepted);
    res_t e;
    @(negedge clk);
    bus.in_valid = v; bus.in_data = d; bus.in_amt = a; bus.in_op = op; bus.out_ready = ordy;
    #1;
    check("in_ready", bus.in_ready, !bus.out_valid || ordy);
    if (stall_prev) begin
      check("stall_data", bus.out_data, last_data);
      check("stall_carry", bus.out_carry, last_c);
    end
    stall_prev = bus.out_valid && !ordy;
    last_data = bus.out_data;
    last_c = bus.out_carry;
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        drained++;
        check("data", bus.out_data, e.d);
        check("carry", bus.out_carry, e.c);
        check("zero", bus.out_zero, e.d == 16'h0);
      end
    end
    accepted = v && bus.in_ready;
    if (accepted) q.push_back(model(d, int'(a), op));
  endtask
  task automatic send_chk(input vec_t v, input string n);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = v.d; bus.in_amt = 4'(v.a); bus.in_op = v.op; bus.out_ready = 1'b1;
    #1 check({n, "_in_ready"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check({n, "_early"}, bus.out_valid, 0);
    @(negedge clk);
    #1;
    check({n, "_valid"}, bus.out_valid, 1);
    check({n, "_data"}, bus.out_data, v.ed);
    check({n, "_carry"}, bus.out_carry, v.ec);
    check({n, "_zero"}, bus.out_zero, v.ed == 16'h0);
  endtask
  task automatic flush();
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    stall_prev = 1'b0;
  endtask
  initial begin
    tv[0]  = '{2'b00, 1,  16'h8001, 16'h0002, 1'b1};
    tv[1]  = '{2'b10, 15, 16'h8000, 16'hFFFF, 1'b0};
    tv[2]  = '{2'b01, 15, 16'h8000, 16'h0001, 1'b0};
    tv[3]  = '{2'b11, 4,  16'h1234, 16'h4123, 1'b0};
    tv[4]  = '{2'b11, 1,  16'h000F, 16'h8007, 1'b1};
    tv[5]  = '{2'b00, 0,  16'hA5A5, 16'hA5A5, 1'b0};
    tv[6]  = '{2'b01, 0,  16'hA5A5, 16'hA5A5, 1'b0};
    tv[7]  = '{2'b10, 0,  16'hA5A5, 16'hA5A5, 1'b0};
    tv[8]  = '{2'b11, 0,  16'hA5A5, 16'hA5A5, 1'b0};
    tv[9]  = '{2'b01, 1,  16'h0001, 16'h0000, 1'b1};
    tv[10] = '{2'b00, 15, 16'h0001, 16'h8000, 1'b0};
    tv[11] = '{2'b10, 15, 16'h7FFF, 16'h0000, 1'b1};
    tv[12] = '{2'b00, 2,  16'hC000, 16'h0000, 1'b1};
    tv[13] = '{2'b10, 3,  16'h8010, 16'hF002, 1'b0};
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_op = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_flags", {bus.out_carry, bus.out_zero}, 0);
    #9 rst_n = 1'b1;
    #1 check("rst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 14; i++) send_chk(tv[i], $sformatf("vec%0d", i));
    flush();
    // Fill both stages while stalled, then reset between clock edges.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'h0001; bus.in_amt = 4'd4; bus.in_op = 2'b00; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("pre_rst_full", bus.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_data", bus.out_data, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_valid", bus.out_valid, 0);
    send_chk(tv[3], "post_rst");
    flush();
    idx = 0;
    d0 = drained;
    for (int c = 0; c < 30 && !(idx == 4 && q.size() == 0); c++) begin
      cycle(idx < 4, 16'h0001, 4'(idx), 2'b00, c >= 5, acc);
      if (acc) idx++;
      if (c == 3) check("bp_in_ready_low", bus.in_ready, 0);
    end
    check("bp_count", drained - d0, 4);
    check("bp_left", q.size(), 0);
    pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pend) begin
        pend = $urandom_range(0, 9) < 7;
        rd = 16'($urandom);
        ra = 4'($urandom);
        ro = 2'($urandom);
      end
      cycle(pend, rd, ra, ro, $urandom_range(0, 3) != 0, acc);
      if (acc) pend = 1'b0;
    end
    for (int c = 0; c < 10 && q.size() != 0; c++) cycle(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, acc);
    check("rand_drained", q.size(), 0);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = 'x; bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 check("x_no_valid", bus.out_valid, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
